// File: rtl/free_list_pkg.sv
// ---------------------------------------------------------------------------
// typedefs
// Shared rename/retire definitions for the physical-register free list.
// Holds the register-file sizing, the derived FIFO geometry and the
// freeRegStruct that retire hands back to the free list each cycle.
// No ports (package).
// ---------------------------------------------------------------------------
package typedefs;

    localparam int PHYS_REGS = 64;
    localparam int ARCH_REGS = 32;
    localparam int PREG_W    = $clog2(PHYS_REGS);

    // The free list only ever holds registers not mapped at reset, so its
    // capacity is the surplus of physical over architectural registers.
    localparam int DEPTH = PHYS_REGS - ARCH_REGS;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic              valid1;
        logic [PREG_W-1:0] reg1;
        logic              valid2;
        logic [PREG_W-1:0] reg2;
    } freeRegStruct;

endpackage

// File: rtl/free_list_if.sv
// ---------------------------------------------------------------------------
// free_list_if
// Bundles the retire/rename traffic of the free list.
//   freeReg            : registers released by retire (two slots)
//   pop1 / pop2        : rename consumes preg1 / preg2 this cycle
//   preg1 / preg2      : head and head+1 entries
//   avail1 / avail2    : at least one / two entries present
//   count              : current occupancy
//   overflow/underflow : sticky error flags
// master = rename/retire side, slave = the free list itself.
// ---------------------------------------------------------------------------
interface free_list_if;
    import typedefs::*;

    freeRegStruct       freeReg;
    logic               pop1;
    logic               pop2;
    logic [PREG_W-1:0]  preg1;
    logic [PREG_W-1:0]  preg2;
    logic               avail1;
    logic               avail2;
    logic [CNT_W-1:0]   count;
    logic               overflow;
    logic               underflow;

    modport master (
        output freeReg, pop1, pop2,
        input  preg1, preg2, avail1, avail2, count, overflow, underflow
    );

    modport slave (
        input  freeReg, pop1, pop2,
        output preg1, preg2, avail1, avail2, count, overflow, underflow
    );

endinterface

// File: rtl/free_list_fl_ram.sv
// ---------------------------------------------------------------------------
// fl_ram
// DEPTH x PREG_W storage for the free list. Two write ports, two
// asynchronous read ports. On reset entry i holds ARCH_REGS+i so the list
// starts out full of every register not carrying architectural state.
//   clk, reset            : clock, async active-high reset
//   wrEn1/wrAddr1/wrData1 : first write port
//   wrEn2/wrAddr2/wrData2 : second write port
//   rdAddr1/rdData1       : first read port (combinational)
//   rdAddr2/rdData2       : second read port (combinational)
// ---------------------------------------------------------------------------
module fl_ram
    import typedefs::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              wrEn1,
    input  logic [PTR_W-1:0]  wrAddr1,
    input  logic [PREG_W-1:0] wrData1,
    input  logic              wrEn2,
    input  logic [PTR_W-1:0]  wrAddr2,
    input  logic [PREG_W-1:0] wrData2,
    input  logic [PTR_W-1:0]  rdAddr1,
    output logic [PREG_W-1:0] rdData1,
    input  logic [PTR_W-1:0]  rdAddr2,
    output logic [PREG_W-1:0] rdData2
);

    logic [PREG_W-1:0] entries [DEPTH];

    // Storage array. The controller never drives both write ports at the
    // same address (they target tail and tail+1), so write order is moot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= PREG_W'(ARCH_REGS + i);
            end
        end else begin
            if (wrEn1) begin
                entries[wrAddr1] <= wrData1;
            end
            if (wrEn2) begin
                entries[wrAddr2] <= wrData2;
            end
        end
    end

    assign rdData1 = entries[rdAddr1];
    assign rdData2 = entries[rdAddr2];

endmodule

// File: rtl/free_list.sv
// ---------------------------------------------------------------------------
// free_list
// Physical-register free list for the 2-wide rename/retire pipeline.
// A 2-write/2-read circular FIFO with an occupancy counter: retire pushes
// up to two released registers per cycle, rename pops up to two.
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   flIf  : free_list_if.slave (freeReg, pop1/pop2 in; preg1/preg2,
//           avail1/avail2, count, overflow/underflow out)
// ---------------------------------------------------------------------------
module free_list
    import typedefs::*;
(
    input  logic          clk,
    input  logic          reset,
    free_list_if.slave    flIf
);

    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  countQ;
    logic              overflowQ;
    logic              underflowQ;

    logic              avail1;
    logic              avail2;
    logic              popIllegal;
    logic [1:0]        popCount;
    logic              accept1;
    logic              accept2;
    logic [1:0]        pushReq;
    logic [CNT_W-1:0]  countAfterPop;
    logic [CNT_W-1:0]  space;
    logic [1:0]        pushCount;
    logic              pushDropped;
    logic [PREG_W-1:0] firstData;
    logic [CNT_W-1:0]  countNext;

    logic              wrEn1;
    logic              wrEn2;
    logic [PTR_W-1:0]  wrAddr2;
    logic [PTR_W-1:0]  rdAddr2;

    assign avail1 = (countQ != '0);
    assign avail2 = (countQ >= CNT_W'(2));

    // Pop side: any ill-formed or unsatisfiable request is dropped whole so
    // rename never sees half a pair disappear. Pops are judged against the
    // pre-cycle occupancy only.
    always_comb begin
        popIllegal = (flIf.pop2 && !flIf.pop1)
                   || (flIf.pop1 && !avail1)
                   || (flIf.pop2 && !avail2);
        popCount = 2'd0;
        if (!popIllegal) begin
            popCount = {1'b0, flIf.pop1} + {1'b0, flIf.pop2};
        end
    end

    // Push side: p0 is the hard-wired zero register and is never recycled.
    // Accepted pushes are compacted onto tail/tail+1, and room is measured
    // after this cycle's pops so a full list can swap two-for-two. When only
    // one slot remains the second accepted push is the one discarded.
    always_comb begin
        accept1       = flIf.freeReg.valid1 && (flIf.freeReg.reg1 != '0);
        accept2       = flIf.freeReg.valid2 && (flIf.freeReg.reg2 != '0);
        pushReq       = {1'b0, accept1} + {1'b0, accept2};
        countAfterPop = countQ - CNT_W'(popCount);
        space         = CNT_W'(DEPTH) - countAfterPop;

        pushCount = 2'd0;
        if ((pushReq == 2'd2) && (space >= CNT_W'(2))) begin
            pushCount = 2'd2;
        end else if ((pushReq != 2'd0) && (space != '0)) begin
            pushCount = 2'd1;
        end

        pushDropped = (pushCount < pushReq);
        firstData   = accept1 ? flIf.freeReg.reg1 : flIf.freeReg.reg2;
        countNext   = countAfterPop + CNT_W'(pushCount);
    end

    assign wrEn1   = (pushCount != 2'd0);
    assign wrEn2   = (pushCount == 2'd2);
    assign wrAddr2 = tail + PTR_W'(1);
    assign rdAddr2 = head + PTR_W'(1);

    fl_ram ram (
        .clk     (clk),
        .reset   (reset),
        .wrEn1   (wrEn1),
        .wrAddr1 (tail),
        .wrData1 (firstData),
        .wrEn2   (wrEn2),
        .wrAddr2 (wrAddr2),
        .wrData2 (flIf.freeReg.reg2),
        .rdAddr1 (head),
        .rdData1 (flIf.preg1),
        .rdAddr2 (rdAddr2),
        .rdData2 (flIf.preg2)
    );

    // Pointer, occupancy and error state. Pointers are exactly PTR_W bits
    // wide so they wrap modulo DEPTH for free; full and empty both show
    // head==tail and are told apart by countQ.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head       <= '0;
            tail       <= '0;
            countQ     <= CNT_W'(DEPTH);
            overflowQ  <= 1'b0;
            underflowQ <= 1'b0;
        end else begin
            head   <= head + PTR_W'(popCount);
            tail   <= tail + PTR_W'(pushCount);
            countQ <= countNext;
            if (pushDropped) begin
                overflowQ <= 1'b1;
            end
            if (popIllegal) begin
                underflowQ <= 1'b1;
            end
        end
    end

    assign flIf.avail1    = avail1;
    assign flIf.avail2    = avail2;
    assign flIf.count     = countQ;
    assign flIf.overflow  = overflowQ;
    assign flIf.underflow = underflowQ;

endmodule

// File: tb/tb_free_list.sv
// ---------------------------------------------------------------------------
// tb_free_list
// Directed self-checking bench for free_list: reset contents, draining to
// empty, underflow/overflow handling, p0 compaction, two-wide streaming
// across pointer wrap, and asynchronous reset in the middle of traffic.
// ---------------------------------------------------------------------------
module tb_free_list;
    import typedefs::*;

    logic clk = 1'b0;
    logic reset;
    int   testsRun    = 0;
    int   testsFailed = 0;

    free_list_if flIf ();

    free_list dut (
        .clk   (clk),
        .reset (reset),
        .flIf  (flIf)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input int actual, input int expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Return all bench-driven inputs to the quiet state.
    task automatic driveIdle();
        flIf.pop1           = 1'b0;
        flIf.pop2           = 1'b0;
        flIf.freeReg.valid1 = 1'b0;
        flIf.freeReg.reg1   = '0;
        flIf.freeReg.valid2 = 1'b0;
        flIf.freeReg.reg2   = '0;
    endtask

    // Drive one cycle of pops/pushes, let it be clocked in, then idle.
    // On return we sit 1 time unit past the active edge.
    task automatic applyStimulus(input logic p1, input logic p2,
                                 input logic v1, input int r1,
                                 input logic v2, input int r2);
        flIf.pop1           = p1;
        flIf.pop2           = p2;
        flIf.freeReg.valid1 = v1;
        flIf.freeReg.reg1   = PREG_W'(r1);
        flIf.freeReg.valid2 = v2;
        flIf.freeReg.reg2   = PREG_W'(r2);
        @(posedge clk);
        #1;
        driveIdle();
    endtask

    // Pulse the asynchronous reset between clock edges.
    task automatic applyReset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        #1;
    endtask

    // Model for the streaming phase: the list's contents in order.
    logic [PREG_W-1:0] model [$];

    initial begin
        int v1;
        int v2;

        driveIdle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;

        // Reset contents: p32..p63, full.
        checkOutput("rstCount", int'(flIf.count), 32);
        checkOutput("rstPreg1", int'(flIf.preg1), 32);
        checkOutput("rstPreg2", int'(flIf.preg2), 33);
        checkOutput("rstAvail1", int'(flIf.avail1), 1);
        checkOutput("rstAvail2", int'(flIf.avail2), 1);
        checkOutput("rstOverflow", int'(flIf.overflow), 0);
        checkOutput("rstUnderflow", int'(flIf.underflow), 0);

        // Drain with double pops.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 0, 1'b0, 0);
            if (i == 7) begin
                checkOutput("drainMidCount", int'(flIf.count), 16);
                checkOutput("drainMidPreg1", int'(flIf.preg1), 48);
                checkOutput("drainMidPreg2", int'(flIf.preg2), 49);
            end
        end
        checkOutput("emptyCount", int'(flIf.count), 0);
        checkOutput("emptyAvail1", int'(flIf.avail1), 0);
        checkOutput("emptyAvail2", int'(flIf.avail2), 0);
        checkOutput("emptyUnderflow", int'(flIf.underflow), 0);

        // Pop on empty is dropped and flagged.
        applyStimulus(1'b1, 1'b0, 1'b0, 0, 1'b0, 0);
        checkOutput("popEmptyCount", int'(flIf.count), 0);
        checkOutput("popEmptyUnderflow", int'(flIf.underflow), 1);
        checkOutput("popEmptyOverflow", int'(flIf.overflow), 0);

        // Push 40/41 into an empty list with a same-cycle pop1.
        applyReset();
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 0, 1'b0, 0);
        end
        flIf.pop1           = 1'b1;
        flIf.freeReg.valid1 = 1'b1;
        flIf.freeReg.reg1   = PREG_W'(40);
        flIf.freeReg.valid2 = 1'b1;
        flIf.freeReg.reg2   = PREG_W'(41);
        #1;
        checkOutput("noBypassAvail1", int'(flIf.avail1), 0);
        checkOutput("noBypassUnderflow", int'(flIf.underflow), 0);
        @(posedge clk);
        #1;
        driveIdle();
        checkOutput("refillCount", int'(flIf.count), 2);
        checkOutput("refillPreg1", int'(flIf.preg1), 40);
        checkOutput("refillPreg2", int'(flIf.preg2), 41);
        checkOutput("refillAvail2", int'(flIf.avail2), 1);
        checkOutput("refillUnderflow", int'(flIf.underflow), 1);

        // Push into a full list is dropped.
        applyReset();
        applyStimulus(1'b0, 1'b0, 1'b1, 5, 1'b0, 0);
        checkOutput("fullPushCount", int'(flIf.count), 32);
        checkOutput("fullPushOverflow", int'(flIf.overflow), 1);
        checkOutput("fullPushPreg1", int'(flIf.preg1), 32);

        // Same push alongside a double pop uses the freed room.
        applyStimulus(1'b1, 1'b1, 1'b1, 5, 1'b0, 0);
        checkOutput("swapCount", int'(flIf.count), 31);
        checkOutput("swapPreg1", int'(flIf.preg1), 34);
        checkOutput("swapUnderflow", int'(flIf.underflow), 0);
        for (int i = 0; i < 15; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 0, 1'b0, 0);
        end
        checkOutput("swapTailCount", int'(flIf.count), 1);
        checkOutput("swapTailPreg1", int'(flIf.preg1), 5);
        checkOutput("swapTailAvail2", int'(flIf.avail2), 0);

        // p0 in slot 1 is ignored; p7 from slot 2 lands at the old tail.
        applyReset();
        for (int i = 0; i < 11; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 0, 1'b0, 0);
        end
        checkOutput("compactPreCount", int'(flIf.count), 10);
        checkOutput("compactPrePreg1", int'(flIf.preg1), 54);
        applyStimulus(1'b0, 1'b0, 1'b1, 0, 1'b1, 7);
        checkOutput("compactCount", int'(flIf.count), 11);
        checkOutput("compactOverflow", int'(flIf.overflow), 0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 0, 1'b0, 0);
        end
        checkOutput("compactTailCount", int'(flIf.count), 1);
        checkOutput("compactTailPreg1", int'(flIf.preg1), 7);

        // Two-in/two-out streaming on a full list across pointer wrap.
        applyReset();
        model.delete();
        for (int i = 0; i < 32; i++) begin
            model.push_back(PREG_W'(32 + i));
        end
        for (int c = 0; c < 40; c++) begin
            checkOutput($sformatf("streamPreg1[%0d]", c), int'(flIf.preg1), int'(model[0]));
            checkOutput($sformatf("streamPreg2[%0d]", c), int'(flIf.preg2), int'(model[1]));
            v1 = ((2 * c) % 63) + 1;
            v2 = ((2 * c + 1) % 63) + 1;
            applyStimulus(1'b1, 1'b1, 1'b1, v1, 1'b1, v2);
            void'(model.pop_front());
            void'(model.pop_front());
            model.push_back(PREG_W'(v1));
            model.push_back(PREG_W'(v2));
            checkOutput($sformatf("streamCount[%0d]", c), int'(flIf.count), 32);
        end
        checkOutput("streamOverflow", int'(flIf.overflow), 0);
        checkOutput("streamUnderflow", int'(flIf.underflow), 0);

        // Reset asserted mid-traffic takes effect without a clock edge.
        flIf.pop1           = 1'b1;
        flIf.pop2           = 1'b1;
        flIf.freeReg.valid1 = 1'b1;
        flIf.freeReg.reg1   = PREG_W'(9);
        flIf.freeReg.valid2 = 1'b1;
        flIf.freeReg.reg2   = PREG_W'(10);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("midRstCount", int'(flIf.count), 32);
        checkOutput("midRstPreg1", int'(flIf.preg1), 32);
        checkOutput("midRstPreg2", int'(flIf.preg2), 33);
        @(posedge clk);
        #1;
        driveIdle();
        reset = 1'b0;
        #1;
        checkOutput("postRstCount", int'(flIf.count), 32);
        checkOutput("postRstPreg1", int'(flIf.preg1), 32);
        checkOutput("postRstOverflow", int'(flIf.overflow), 0);
        checkOutput("postRstUnderflow", int'(flIf.underflow), 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
